// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and
// MEM-stage data access (DM). DM has priority; a starvation counter forces an
// IF grant after STARVE_LIMIT consecutive DM grants with IF waiting. One
// transaction in flight; an IF flush drops a stale fetch response.
//
// Ports
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   if_req/if_addr/if_flush    fetch request, address, redirect kill
//   if_valid/if_rdata          fetch response pulse and data
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be             data request, direction, address, write data, byte enables
//   dm_valid/dm_rdata          data completion pulse and read data (0 for writes)
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be           memory request (held until mem_ack) and payload
//   mem_ack/mem_rvalid/
//   mem_rdata                  memory accept, response strobe, response data
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_valid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]        state,      state_d;
    logic              owner_dm,   owner_dm_d;
    logic [CNT_W-1:0]  starve_cnt, starve_cnt_d;
    logic              drop,       drop_d;
    logic              mem_req_d,  mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [BE_W-1:0]   mem_be_d;
    logic              if_valid_d, dm_valid_d;
    logic [DATA_W-1:0] if_rdata_d, dm_rdata_d;

    logic if_elig_c;
    logic starved_c;
    logic dm_win_c;
    logic flush_hit_c;

    // Arbitration terms; a flushing IF cannot win nor force a grant this cycle.
    assign if_elig_c   = if_req & ~if_flush;
    assign starved_c   = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign dm_win_c    = dm_req & ~(if_elig_c & starved_c);
    assign flush_hit_c = ~owner_dm & if_flush;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner_dm   <= 1'b0;
            starve_cnt <= '0;
            drop       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_valid   <= 1'b0;
            dm_rdata   <= '0;
        end else begin
            state      <= state_d;
            owner_dm   <= owner_dm_d;
            starve_cnt <= starve_cnt_d;
            drop       <= drop_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_be     <= mem_be_d;
            if_valid   <= if_valid_d;
            if_rdata   <= if_rdata_d;
            dm_valid   <= dm_valid_d;
            dm_rdata   <= dm_rdata_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        owner_dm_d   = owner_dm;
        starve_cnt_d = starve_cnt;
        drop_d       = drop;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_be_d     = mem_be;
        if_valid_d   = 1'b0;
        if_rdata_d   = if_rdata;
        dm_valid_d   = 1'b0;
        dm_rdata_d   = dm_rdata;

        case (state)
            ST_IDLE: begin
                if (dm_win_c) begin
                    state_d     = ST_REQ;
                    owner_dm_d  = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_be_d    = dm_be;
                    // Count DM wins while IF waits; saturate at the limit.
                    if (!if_req)
                        starve_cnt_d = '0;
                    else if (!starved_c)
                        starve_cnt_d = starve_cnt + CNT_W'(1);
                end else if (if_elig_c) begin
                    state_d      = ST_REQ;
                    owner_dm_d   = 1'b0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
                    mem_be_d     = {BE_W{1'b1}};
                    starve_cnt_d = '0;
                end
            end
            ST_REQ: begin
                if (flush_hit_c)
                    drop_d = 1'b1;
                if (mem_ack) begin
                    state_d   = ST_WAIT;
                    mem_req_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (flush_hit_c)
                    drop_d = 1'b1;
                if (mem_rvalid) begin
                    state_d = ST_RESP;
                    if (owner_dm) begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = mem_we ? '0 : mem_rdata;
                    end else if (!(drop | flush_hit_c)) begin
                        // A flush in the response cycle still discards it.
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_valid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_we, mem_ack, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] s_addr, s_wdata;
    logic        s_we;
    logic [3:0]  s_be;
    int          s_wait;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory side of one transaction: wait for mem_req, stall ack_wait cycles,
    // ack, then respond the next cycle. Returns at the edge where valid is due.
    task automatic serve(input int ack_wait, input logic [31:0] rd);
        s_wait = 0;
        while (mem_req !== 1'b1 && s_wait < 20) begin
            @(negedge clk);
            s_wait++;
        end
        check_eq("req_seen", 64'(mem_req), 64'd1);
        s_addr  = mem_addr;
        s_we    = mem_we;
        s_wdata = mem_wdata;
        s_be    = mem_be;
        repeat (ack_wait) begin
            @(negedge clk);
            check_eq("stall_req", 64'(mem_req), 64'd1);
            check_eq("stall_payload", {mem_addr, mem_wdata}, {s_addr, s_wdata});
            check_eq("stall_ctl", {59'd0, mem_we, mem_be}, {59'd0, s_we, s_be});
            check_eq("stall_valid", {62'd0, if_valid, dm_valid}, 64'd0);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack    = 1'b0;
        check_eq("req_dropped", 64'(mem_req), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = 0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
        mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_outs", {59'd0, mem_req, mem_we, if_valid, dm_valid, 1'b0}, 64'd0);
        check_eq("rst_addr", 64'(mem_addr), 64'd0);
        rst = 1'b0;

        // 1: reset in the middle of WAIT
        if_req = 1; if_addr = 32'h80;
        @(negedge clk);
        check_eq("t1_req", 64'(mem_req), 64'd1);
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0; rst = 1; if_req = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        check_eq("t1_idle", {61'd0, mem_req, if_valid, dm_valid}, 64'd0);
        mem_rvalid = 1; mem_rdata = 32'h11111111;
        @(negedge clk);
        mem_rvalid = 0;
        repeat (2) begin
            @(negedge clk);
            check_eq("t1_no_resp", {61'd0, mem_req, if_valid, dm_valid}, 64'd0);
        end

        // 2: IF alone, minimum latency
        if_req = 1; if_addr = 32'h100;
        serve(0, 32'h00500093);
        check_eq("t2_lat", 64'(s_wait), 64'd1);
        check_eq("t2_addr", 64'(s_addr), 64'h100);
        check_eq("t2_be_we", {59'd0, s_we, s_be}, 64'h0F);
        check_eq("t2_valid", {62'd0, if_valid, dm_valid}, 64'b10);
        check_eq("t2_rdata", 64'(if_rdata), 64'h00500093);
        if_req = 0;
        @(negedge clk);
        check_eq("t2_pulse", 64'(if_valid), 64'd0);

        // 3: simultaneous requests, DM write first
        if_req = 1; if_addr = 32'h104;
        dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_be = 4'h3;
        serve(0, 32'h12345678);
        check_eq("t3_dm_addr", 64'(s_addr), 64'h2000);
        check_eq("t3_dm_wd", 64'(s_wdata), 64'hDEADBEEF);
        check_eq("t3_dm_ctl", {59'd0, s_we, s_be}, 64'h13);
        check_eq("t3_dm_valid", {62'd0, if_valid, dm_valid}, 64'b01);
        check_eq("t3_dm_rdata", 64'(dm_rdata), 64'd0);
        dm_req = 0; dm_we = 0;
        serve(0, 32'h00A00113);
        check_eq("t3_if_addr", 64'(s_addr), 64'h104);
        check_eq("t3_if_ctl", {59'd0, s_we, s_be}, 64'h0F);
        check_eq("t3_if_valid", {62'd0, if_valid, dm_valid}, 64'b10);
        check_eq("t3_if_rdata", 64'(if_rdata), 64'h00A00113);
        if_req = 0;
        @(negedge clk);

        // 4: starvation with both requesters always busy
        rst = 1;
        @(negedge clk);
        rst = 0;
        dm_req = 1; dm_we = 0; dm_addr = 32'h3000; dm_be = 4'hF;
        if_req = 1; if_addr = 32'h400;
        for (int i = 0; i < 10; i++) begin
            logic exp_if;
            exp_if = (i == 4) || (i == 9);
            serve(0, 32'h100 + 32'(i));
            check_eq($sformatf("t4_grant%0d", i), 64'(s_addr), exp_if ? 64'h400 : 64'h3000);
            check_eq($sformatf("t4_valid%0d", i), {62'd0, if_valid, dm_valid},
                     exp_if ? 64'b10 : 64'b01);
            check_eq($sformatf("t4_data%0d", i), 64'(exp_if ? if_rdata : dm_rdata),
                     64'h100 + 64'(i));
        end
        dm_req = 0; if_req = 0;
        repeat (2) @(negedge clk);

        // 5: flush while IF waits for its response
        if_req = 1; if_addr = 32'h180;
        @(negedge clk);
        check_eq("t5_req", 64'(mem_req), 64'd1);
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0; if_flush = 1; if_req = 0;
        @(negedge clk);
        if_flush = 0;
        @(negedge clk);
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        mem_rvalid = 0;
        check_eq("t5_dropped", {62'd0, if_valid, dm_valid}, 64'd0);
        @(negedge clk);
        check_eq("t5_idle", {61'd0, mem_req, if_valid, dm_valid}, 64'd0);
        if_req = 1; if_addr = 32'h200;
        serve(0, 32'h00000513);
        check_eq("t5_lat", 64'(s_wait), 64'd1);
        check_eq("t5_addr", 64'(s_addr), 64'h200);
        check_eq("t5_valid", 64'(if_valid), 64'd1);
        check_eq("t5_rdata", 64'(if_rdata), 64'h00000513);
        if_req = 0;
        @(negedge clk);

        // 6: memory stall on a DM read
        dm_req = 1; dm_we = 0; dm_addr = 32'h5000; dm_wdata = 32'h0; dm_be = 4'hF;
        serve(5, 32'hCAFEF00D);
        check_eq("t6_addr", 64'(s_addr), 64'h5000);
        check_eq("t6_valid", {62'd0, if_valid, dm_valid}, 64'b01);
        check_eq("t6_rdata", 64'(dm_rdata), 64'hCAFEF00D);
        dm_req = 0;
        @(negedge clk);
        check_eq("t6_pulse", 64'(dm_valid), 64'd0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
